// File: rtl/branch_history_tracker_pkg.sv
// Shared definitions for the branch history tracker and its checkpoint queue.
// The GHR width and checkpoint depth defaults are shared with the gshare predictor.
package branch_history_tracker_pkg;

    localparam int GHR_BITS      = 11;
    localparam int BP_CKPT_DEPTH = 8;

    // Source of the next speculative GHR value, listed in priority order.
    typedef enum logic [1:0] {
        GHR_HOLD   = 2'd0,
        GHR_ALLOC  = 2'd1,
        GHR_REPAIR = 2'd2,
        GHR_FLUSH  = 2'd3
    } ghr_sel_e;

endpackage

// File: rtl/branch_history_tracker_ckpt_queue.sv
// Circular checkpoint queue of in-flight conditional branches.
// Head/tail pointers carry a wrap bit; entries retire in order from the head,
// and a mispredict squashes every entry younger than the resolving tag.
module bp_checkpoint_queue
    import branch_history_tracker_pkg::*;
#(
    parameter int DEPTH     = BP_CKPT_DEPTH,
    parameter int HIST_BITS = GHR_BITS,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    // allocation (already qualified by the top level)
    input  logic                 alloc_en_i,
    input  logic [31:0]          alloc_pc_i,
    input  logic                 alloc_pred_i,
    input  logic [HIST_BITS-1:0] alloc_hist_i,
    // lookup of the entry named by a resolve
    input  logic [IDX_W-1:0]     lookup_tag_i,
    output logic                 lookup_valid_o,
    output logic                 lookup_resolved_o,
    output logic                 lookup_pred_o,
    output logic [HIST_BITS-1:0] lookup_hist_o,
    // resolve / squash of the looked-up entry
    input  logic                 resolve_en_i,
    input  logic                 resolve_taken_i,
    input  logic                 squash_en_i,
    input  logic                 flush_i,
    // status
    output logic                 full_o,
    output logic [IDX_W-1:0]     tail_idx_o,
    output logic [IDX_W:0]       occupancy_o,
    // in-order retire of the head entry
    output logic                 retire_o,
    output logic [31:0]          retire_pc_o,
    output logic                 retire_taken_o,
    output logic [HIST_BITS-1:0] retire_hist_o
);

    logic [IDX_W:0]       head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]     valid_q, valid_d, resolved_q, resolved_d;
    logic [DEPTH-1:0]     pred_q, actual_q;
    logic [31:0]          pc_q   [DEPTH];
    logic [HIST_BITS-1:0] hist_q [DEPTH];

    logic [IDX_W-1:0]     head_idx, tail_idx, tag_off;
    logic [DEPTH-1:0]     younger;
    logic                 tag_wrap;
    logic [IDX_W:0]       squash_tail;

    assign head_idx    = head_q[IDX_W-1:0];
    assign tail_idx    = tail_q[IDX_W-1:0];
    assign full_o      = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign tail_idx_o  = tail_idx;
    assign occupancy_o = tail_q - head_q;

    assign lookup_valid_o    = valid_q[lookup_tag_i];
    assign lookup_resolved_o = resolved_q[lookup_tag_i];
    assign lookup_pred_o     = pred_q[lookup_tag_i];
    assign lookup_hist_o     = hist_q[lookup_tag_i];

    // Retire reads the registered resolved bit, so resolve-to-retire is at least one cycle.
    assign retire_o       = valid_q[head_idx] & resolved_q[head_idx];
    assign retire_pc_o    = pc_q[head_idx];
    assign retire_taken_o = actual_q[head_idx];
    assign retire_hist_o  = hist_q[head_idx];

    // A tag at or above the head index sits in the head's lap; below it, in the next lap.
    assign tag_wrap    = (lookup_tag_i >= head_idx) ? head_q[IDX_W] : ~head_q[IDX_W];
    assign squash_tail = {tag_wrap, lookup_tag_i} + (IDX_W+1)'(1);
    assign tag_off     = lookup_tag_i - head_idx;

    // Mark entries whose age (distance from head) exceeds that of the squashing tag.
    always_comb begin
        logic [IDX_W-1:0] off;
        younger = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = IDX_W'(i) - head_idx;
            younger[i] = (off > tag_off);
        end
    end

    // Next-state for pointers and per-entry control bits; later writes take priority.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q;
        resolved_d = resolved_q;
        if (retire_o) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + (IDX_W+1)'(1);
        end
        if (resolve_en_i) begin
            resolved_d[lookup_tag_i] = 1'b1;
        end
        if (squash_en_i) begin
            valid_d = valid_d & ~younger;
            tail_d  = squash_tail;
        end
        if (alloc_en_i) begin
            valid_d[tail_idx]    = 1'b1;
            resolved_d[tail_idx] = 1'b0;
            tail_d               = tail_q + (IDX_W+1)'(1);
        end
        if (flush_i) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= '0;
            resolved_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            resolved_q <= resolved_d;
        end
    end

    // Checkpoint payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc_en_i) begin
            pc_q[tail_idx]   <= alloc_pc_i;
            pred_q[tail_idx] <= alloc_pred_i;
            hist_q[tail_idx] <= alloc_hist_i;
        end
        if (resolve_en_i) begin
            actual_q[lookup_tag_i] <= resolve_taken_i;
        end
    end

endmodule

// File: rtl/branch_history_tracker.sv
// Producer side of the gshare training interface: speculative and committed
// GHRs, resolve compare with history repair, and the registered update port.
module branch_history_tracker
    import branch_history_tracker_pkg::*;
#(
    parameter int DEPTH     = BP_CKPT_DEPTH,
    parameter int HIST_BITS = GHR_BITS,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid_i,
    input  logic [31:0]          alloc_pc_i,
    input  logic                 alloc_pred_taken_i,
    output logic                 alloc_ready_o,
    output logic [IDX_W-1:0]     alloc_tag_o,
    output logic [HIST_BITS-1:0] global_history_o,
    input  logic                 resolve_valid_i,
    input  logic [IDX_W-1:0]     resolve_tag_i,
    input  logic                 resolve_taken_i,
    output logic                 mispredict_o,
    input  logic                 flush_i,
    output logic                 update_valid_o,
    output logic [31:0]          update_pc_o,
    output logic                 update_taken_o,
    output logic [HIST_BITS-1:0] update_history_o,
    output logic [IDX_W:0]       occupancy_o
);

    logic [HIST_BITS-1:0] spec_ghr_q, spec_ghr_d, commit_ghr_q, commit_ghr_d;
    logic                 mispredict_q, update_valid_q, update_taken_q;
    logic [31:0]          update_pc_q;
    logic [HIST_BITS-1:0] update_hist_q;

    logic                 full, lk_valid, lk_resolved, lk_pred;
    logic [HIST_BITS-1:0] lk_hist;
    logic [IDX_W-1:0]     tail_idx;
    logic                 retire, retire_taken;
    logic [31:0]          retire_pc;
    logic [HIST_BITS-1:0] retire_hist;
    logic                 resolve_acc, misp_now, alloc_fire;
    ghr_sel_e             ghr_sel;

    // A flush swallows any resolve in the same cycle; recovery then blocks allocation.
    assign resolve_acc = resolve_valid_i & lk_valid & ~lk_resolved & ~flush_i;
    assign misp_now    = resolve_acc & (resolve_taken_i != lk_pred);
    assign alloc_fire  = alloc_valid_i & ~full & ~flush_i & ~misp_now;

    assign alloc_ready_o    = ~full;
    assign alloc_tag_o      = tail_idx;
    assign global_history_o = spec_ghr_q;
    assign mispredict_o     = mispredict_q;
    assign update_valid_o   = update_valid_q;
    assign update_pc_o      = update_pc_q;
    assign update_taken_o   = update_taken_q;
    assign update_history_o = update_hist_q;

    bp_checkpoint_queue #(
        .DEPTH     (DEPTH),
        .HIST_BITS (HIST_BITS)
    ) u_queue (
        .clk               (clk),
        .rst               (rst),
        .alloc_en_i        (alloc_fire),
        .alloc_pc_i        (alloc_pc_i),
        .alloc_pred_i      (alloc_pred_taken_i),
        .alloc_hist_i      (spec_ghr_q),
        .lookup_tag_i      (resolve_tag_i),
        .lookup_valid_o    (lk_valid),
        .lookup_resolved_o (lk_resolved),
        .lookup_pred_o     (lk_pred),
        .lookup_hist_o     (lk_hist),
        .resolve_en_i      (resolve_acc),
        .resolve_taken_i   (resolve_taken_i),
        .squash_en_i       (misp_now),
        .flush_i           (flush_i),
        .full_o            (full),
        .tail_idx_o        (tail_idx),
        .occupancy_o       (occupancy_o),
        .retire_o          (retire),
        .retire_pc_o       (retire_pc),
        .retire_taken_o    (retire_taken),
        .retire_hist_o     (retire_hist)
    );

    assign commit_ghr_d = retire ? {commit_ghr_q[HIST_BITS-2:0], retire_taken} : commit_ghr_q;

    // Pick the speculative GHR source: flush > mispredict repair > alloc shift.
    always_comb begin
        ghr_sel = GHR_HOLD;
        if (flush_i)         ghr_sel = GHR_FLUSH;
        else if (misp_now)   ghr_sel = GHR_REPAIR;
        else if (alloc_fire) ghr_sel = GHR_ALLOC;
    end

    // Form the next speculative GHR; a flush includes a same-cycle retire's outcome.
    always_comb begin
        spec_ghr_d = spec_ghr_q;
        unique case (ghr_sel)
            GHR_FLUSH:  spec_ghr_d = commit_ghr_d;
            GHR_REPAIR: spec_ghr_d = {lk_hist[HIST_BITS-2:0], resolve_taken_i};
            GHR_ALLOC:  spec_ghr_d = {spec_ghr_q[HIST_BITS-2:0], alloc_pred_taken_i};
            default:    spec_ghr_d = spec_ghr_q;
        endcase
    end

    // History registers, mispredict pulse and the registered training port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ghr_q     <= '0;
            commit_ghr_q   <= '0;
            mispredict_q   <= 1'b0;
            update_valid_q <= 1'b0;
            update_pc_q    <= '0;
            update_taken_q <= 1'b0;
            update_hist_q  <= '0;
        end else begin
            spec_ghr_q     <= spec_ghr_d;
            commit_ghr_q   <= commit_ghr_d;
            mispredict_q   <= misp_now;
            update_valid_q <= retire;
            if (retire) begin
                update_pc_q    <= retire_pc;
                update_taken_q <= retire_taken;
                update_hist_q  <= retire_hist;
            end
        end
    end

endmodule

// File: tb/tb_branch_history_tracker.sv
// Bench for branch_history_tracker: directed scenarios followed by random traffic,
// all checked against a program-order queue model of in-flight branches.
module tb_branch_history_tracker;

    localparam int DEPTH = 8;
    localparam int HB    = 11;
    localparam int IW    = 3;
    localparam int MASK  = (1 << HB) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alloc_valid_i = 1'b0;
    logic [31:0]   alloc_pc_i = '0;
    logic          alloc_pred_taken_i = 1'b0;
    logic          alloc_ready_o;
    logic [IW-1:0] alloc_tag_o;
    logic [HB-1:0] global_history_o;
    logic          resolve_valid_i = 1'b0;
    logic [IW-1:0] resolve_tag_i = '0;
    logic          resolve_taken_i = 1'b0;
    logic          mispredict_o;
    logic          flush_i = 1'b0;
    logic          update_valid_o;
    logic [31:0]   update_pc_o;
    logic          update_taken_o;
    logic [HB-1:0] update_history_o;
    logic [IW:0]   occupancy_o;

    branch_history_tracker #(.DEPTH(DEPTH), .HIST_BITS(HB)) dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_valid_i      (alloc_valid_i),
        .alloc_pc_i         (alloc_pc_i),
        .alloc_pred_taken_i (alloc_pred_taken_i),
        .alloc_ready_o      (alloc_ready_o),
        .alloc_tag_o        (alloc_tag_o),
        .global_history_o   (global_history_o),
        .resolve_valid_i    (resolve_valid_i),
        .resolve_tag_i      (resolve_tag_i),
        .resolve_taken_i    (resolve_taken_i),
        .mispredict_o       (mispredict_o),
        .flush_i            (flush_i),
        .update_valid_o     (update_valid_o),
        .update_pc_o        (update_pc_o),
        .update_taken_o     (update_taken_o),
        .update_history_o   (update_history_o),
        .occupancy_o        (occupancy_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          tag;
        logic [31:0] pc;
        bit          pred;
        int          hist;
        bit          res;
        bit          act;
    } ent_t;

    ent_t        mq[$];
    int          m_head, m_spec, m_commit, m_uh;
    bit          m_misp, m_uv, m_ut;
    logic [31:0] m_upc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head = 0; m_spec = 0; m_commit = 0; m_uh = 0;
        m_misp = 0; m_uv = 0; m_ut = 0; m_upc = '0;
    endtask

    task automatic check_outputs();
        chk("global_history", global_history_o, 64'(m_spec));
        chk("occupancy", occupancy_o, 64'(mq.size()));
        chk("mispredict", mispredict_o, 64'(m_misp));
        chk("update_valid", update_valid_o, 64'(m_uv));
        chk("update_pc", update_pc_o, 64'(m_upc));
        chk("update_taken", update_taken_o, 64'(m_ut));
        chk("update_history", update_history_o, 64'(m_uh));
    endtask

    // One clock: check combinational outputs, drive inputs, advance the model, check after edge.
    task automatic step(input bit av, input logic [31:0] apc, input bit apt,
                        input bit rv, input int rtag, input bit rt, input bit fl);
        bit   do_ret, ready, misp;
        int   found;
        ent_t re, e;
        chk("alloc_ready", alloc_ready_o, 64'(mq.size() < DEPTH));
        chk("alloc_tag", alloc_tag_o, 64'((m_head + mq.size()) % DEPTH));
        alloc_valid_i      = av;
        alloc_pc_i         = apc;
        alloc_pred_taken_i = apt;
        resolve_valid_i    = rv;
        resolve_tag_i      = rtag[IW-1:0];
        resolve_taken_i    = rt;
        flush_i            = fl;

        ready  = mq.size() < DEPTH;
        do_ret = (mq.size() > 0) && mq[0].res;
        if (do_ret) re = mq[0];
        misp = 0;
        if (rv && !fl) begin
            found = -1;
            for (int i = 0; i < mq.size(); i++)
                if (found < 0 && mq[i].tag == rtag && !mq[i].res) found = i;
            if (found >= 0) begin
                mq[found].res = 1;
                mq[found].act = rt;
                if (rt != mq[found].pred) begin
                    misp   = 1;
                    m_spec = ((mq[found].hist << 1) | int'(rt)) & MASK;
                    while (mq.size() > found + 1) void'(mq.pop_back());
                end
            end
        end
        m_uv = do_ret;
        if (do_ret) begin
            m_upc    = re.pc;
            m_ut     = re.act;
            m_uh     = re.hist;
            m_commit = ((m_commit << 1) | int'(re.act)) & MASK;
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (av && ready && !fl && !misp) begin
            e.tag  = (m_head + mq.size()) % DEPTH;
            e.pc   = apc;
            e.pred = apt;
            e.hist = m_spec;
            e.res  = 0;
            e.act  = 0;
            mq.push_back(e);
            m_spec = ((m_spec << 1) | int'(apt)) & MASK;
        end
        if (fl) begin
            mq.delete();
            m_head = 0;
            m_spec = m_commit;
        end
        m_misp = misp;

        @(posedge clk);
        #1;
        check_outputs();
        alloc_valid_i   = 1'b0;
        resolve_valid_i = 1'b0;
        flush_i         = 1'b0;
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input logic [31:0] pc, input bit pred);
        step(1, pc, pred, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int tag, input bit taken);
        step(0, 32'h0, 0, 1, tag, taken, 0);
    endtask

    // Asynchronous reset between clock edges; outputs must drop before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rst_alloc_ready", alloc_ready_o, 64'd1);
        chk("rst_alloc_tag", alloc_tag_o, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   pr;
        int   rtag;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // three allocations, in-order retire of out-of-order resolves
        alloc(32'h100, 1);
        alloc(32'h104, 0);
        alloc(32'h108, 1);
        chk("t1_ghr", global_history_o, 64'b101);
        chk("t1_occ", occupancy_o, 64'd3);
        chk("t1_next_tag", alloc_tag_o, 64'd3);
        resolve(2, 1);
        resolve(0, 1);
        chk("t2_no_update_yet", update_valid_o, 64'd0);
        resolve(1, 0);
        chk("t2_upd0_pc", update_pc_o, 64'h100);
        chk("t2_upd0_hist", update_history_o, 64'd0);
        idle();
        chk("t2_upd1_pc", update_pc_o, 64'h104);
        chk("t2_upd1_hist", update_history_o, 64'b1);
        idle();
        chk("t2_upd2_pc", update_pc_o, 64'h108);
        chk("t2_upd2_hist", update_history_o, 64'b10);
        idle();
        chk("t2_upd_done", update_valid_o, 64'd0);

        // fill the queue; ninth alloc dropped; ready returns two cycles after resolve
        for (int i = 0; i < DEPTH; i++) alloc(32'h200 + 32'(4 * i), bit'(i % 2));
        chk("t3_full_ready", alloc_ready_o, 64'd0);
        chk("t3_full_occ", occupancy_o, 64'd8);
        alloc(32'h300, 1);
        chk("t3_drop_occ", occupancy_o, 64'd8);
        resolve(3, 0);
        chk("t3_ready_after1", alloc_ready_o, 64'd0);
        idle();
        chk("t3_ready_after2", alloc_ready_o, 64'd1);
        chk("t3_retire_pc", update_pc_o, 64'h200);

        // reset in the middle of a busy queue
        do_reset();

        // mispredict on tag 1 squashes tags 2..3
        for (int i = 0; i < 4; i++) alloc(32'h400 + 32'(4 * i), 1);
        chk("t4_ghr_pre", global_history_o, 64'b1111);
        resolve(1, 0);
        chk("t4_misp", mispredict_o, 64'd1);
        chk("t4_ghr", global_history_o, 64'b10);
        chk("t4_occ", occupancy_o, 64'd2);
        idle();
        chk("t4_misp_pulse", mispredict_o, 64'd0);
        resolve(3, 1);
        chk("t4_ignored_misp", mispredict_o, 64'd0);
        chk("t4_ignored_upd", update_valid_o, 64'd0);
        chk("t4_next_tag", alloc_tag_o, 64'd2);

        // mispredict with a same-cycle alloc: alloc discarded, tail = tag+1
        alloc(32'h500, 1);
        chk("t5_ghr", global_history_o, 64'b101);
        step(1, 32'h600, 1, 1, 2, 0, 0);
        chk("t5_misp", mispredict_o, 64'd1);
        chk("t5_tag", alloc_tag_o, 64'd3);
        chk("t5_occ", occupancy_o, 64'd3);
        chk("t5_ghr", global_history_o, 64'b100);

        // retire two taken branches, allocate three more, flush
        do_reset();
        alloc(32'h700, 1);
        alloc(32'h704, 1);
        resolve(0, 1);
        resolve(1, 1);
        idle();
        idle();
        for (int i = 0; i < 3; i++) alloc(32'h800 + 32'(4 * i), 0);
        step(0, 32'h0, 0, 0, 0, 0, 1);
        chk("t6_ghr", global_history_o, 64'b11);
        chk("t6_occ", occupancy_o, 64'd0);
        idle();
        chk("t6_no_update", update_valid_o, 64'd0);
        chk("t6_tag", alloc_tag_o, 64'd0);
        idle();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            pr   = bit'($urandom_range(0, 1));
            rtag = int'($urandom_range(0, DEPTH - 1));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                rtag = mq[$urandom_range(0, mq.size() - 1)].tag;
            step(bit'($urandom_range(0, 1)), {$urandom_range(0, 32'h3fff_ffff), 2'b00}, pr,
                 $urandom_range(0, 2) != 0, rtag, bit'($urandom_range(0, 1)),
                 $urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
